wb_master_arbiter: RTL and testbench
====================================

// Module: wb_master_arbiter
// PURPOSE
//  Two-master Wishbone arbiter in front of the single caravel_ips WB slave port.
//  Master 0 is the management SoC WB port; master 1 is a secondary master, e.g. an LA-driven debug master.
//  Round-robin grant at cycle granularity: a granted master keeps the slave for its whole CYC.
//  Arbitration only; no address decode, no data buffering.
// PARAMETERS
//  AW              32   address width
//  DW              32   data width (sel width = DW/8)
//  TIMEOUT_CYCLES  255  stall limit, only used with WB_ARB_TIMEOUT_EN
// PORTS
//  wb_clk_i     in   1      clock; all logic on rising edge
//  wb_rst_i     in   1      synchronous, active-high reset
//  mN_cyc_i     in   1      master N (N=0,1) cycle request
//  mN_stb_i     in   1      master N strobe
//  mN_we_i      in   1      master N write enable
//  mN_sel_i     in   DW/8   master N byte select
//  mN_adr_i     in   AW     master N address
//  mN_dat_i     in   DW     master N write data
//  mN_ack_o     out  1      master N acknowledge
//  mN_dat_o     out  DW     master N read data
//  s_cyc_o / s_stb_o / s_we_o  out  1   to slave
//  s_sel_o      out  DW/8   to slave
//  s_adr_o      out  AW     to slave
//  s_dat_o      out  DW     to slave
//  s_ack_i      in   1      from slave
//  s_dat_i      in   DW     from slave
//  err_o        out  1      sticky timeout flag (0 when feature absent)
//  err_clr_i    in   1      clears err_o
// BEHAVIOUR
//  FSM states: IDLE, GNT0, GNT1. Registers: state, last (id of last granted master).
//  IDLE -> GNTn on the edge where mN_cyc_i=1.
//   Both requesting: grant goes to !last. Only one requesting: grant goes to it.
//  GNTn -> IDLE on the edge where mN_cyc_i=0. A new grant therefore waits one IDLE cycle (bus turnaround).
//  Latency: cyc rise -> s_cyc_o high after 1 clock. Slave ack -> master ack is combinational (0 cycles).
//  Outputs in GNTn (combinational on state):
//   s_* = mN_* gated by mN_cyc_i.
//   mN_ack_o = s_ack_i; mN_dat_o = s_dat_i.
//   Non-granted master: ack_o = 0, dat_o = 0.
//  IDLE: s_cyc_o = s_stb_o = s_we_o = 0; sel/adr/dat = 0; both master acks = 0.
//  Reset: state = IDLE, last = 1 (m0 wins the first tie), err_o = 0. All outputs take their IDLE values.
//  Reset mid-transfer: s_cyc_o drops on the same edge. A slave ack arriving in that cycle is discarded.
//  A master dropping cyc while a stb is pending abandons the transfer. The arbiter does not wait for ack.
//  err_clr_i and a new timeout in the same cycle: the set wins.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - Counter increments each cycle s_stb_o=1 && s_ack_i=0; clears on ack or in IDLE.
//   - At TIMEOUT_CYCLES: one-cycle mN_ack_o=1 with mN_dat_o=32'hDEAD_BEEF, err_o set.
//   - Same edge: forced to IDLE and s_cyc_o/s_stb_o dropped.
//   - The master must deassert cyc. A still-high cyc is re-arbitrated normally.
//  Not defined: no counter, err_o tied 0, err_clr_i ignored.
// STRUCTURE
//  Package wb_arb_pkg: state enum {IDLE,GNT0,GNT1}, master id constants M0/M1, TIMEOUT_DATA = 32'hDEAD_BEEF.
//  Sub-module wb_arb_timeout (stall counter + sticky err), instantiated only under WB_ARB_TIMEOUT_EN.
//  Grant FSM and muxes are in the top module.
// TESTING
//  1. m0 reads 0x3000_0000, slave acks on the 3rd stb cycle:
//     s_cyc rises 1 clk after m0_cyc; m0_ack pulses with slave data; m1_ack stays 0.
//  2. m0_cyc and m1_cyc rise together after reset:
//     m0 granted first; after m0 drops cyc, 1 IDLE cycle, then m1 granted.
//  3. Both masters request continuously, 4 single-beat cycles each:
//     grants strictly alternate m0,m1,m0,m1...
//  4. m1 burst of 3 writes under one cyc while m0 requests:
//     m0 is not granted until m1_cyc falls; 3 acks go to m1 only.
//  5. wb_rst_i asserted mid-transfer in GNT1: next edge s_cyc_o=0 and state IDLE; a later tie grants m0.
//  6. (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never acks:
//     master ack with 0xDEADBEEF after 8 stall cycles, err_o=1 until err_clr_i.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_arb_timeout.sv
// Slave stall watchdog: counts unacknowledged strobe cycles and raises a sticky error.
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic stall_i,
  input  logic ack_i,
  input  logic err_clr_i,
  output logic timeout_o,
  output logic err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout_o = stall_i && (cnt_q == CntW'(TIMEOUT_CYCLES));
  assign err_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!active_i || ack_i || timeout_o) begin
        cnt_q <= '0;
      end else if (stall_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A fresh timeout takes priority over a clear in the same cycle.
      if (timeout_o) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter; grant held for a master's whole CYC.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic            err_o,
  input  logic            err_clr_i
);

  state_e state_q;
  logic   last_q;
  logic   timeout;
  logic   gnt_stb;

  assign gnt_stb = ((state_q == GNT0) && m0_cyc_i && m0_stb_i) ||
                   ((state_q == GNT1) && m1_cyc_i && m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .active_i (state_q != IDLE),
    .stall_i  (gnt_stb && !s_ack_i),
    .ack_i    (s_ack_i),
    .err_clr_i(err_clr_i),
    .timeout_o(timeout),
    .err_o    (err_o)
  );
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(TIMEOUT_CYCLES) ^ {31'b0, err_clr_i};
  assign timeout    = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= M1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // On a tie the master that did not win last time gets the bus.
          if (m0_cyc_i && (!m1_cyc_i || last_q == M1)) begin
            state_q <= GNT0;
            last_q  <= M0;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            last_q  <= M1;
          end
        end
        GNT0:    if (!m0_cyc_i || timeout) state_q <= IDLE;
        GNT1:    if (!m1_cyc_i || timeout) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i;
        s_we_o   = m0_cyc_i & m0_we_i;
        s_sel_o  = m0_cyc_i ? m0_sel_i : '0;
        s_adr_o  = m0_cyc_i ? m0_adr_i : '0;
        s_dat_o  = m0_cyc_i ? m0_dat_i : '0;
        m0_ack_o = s_ack_i | timeout;
        m0_dat_o = timeout ? DW'(TIMEOUT_DATA) : s_dat_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i;
        s_we_o   = m1_cyc_i & m1_we_i;
        s_sel_o  = m1_cyc_i ? m1_sel_i : '0;
        s_adr_o  = m1_cyc_i ? m1_adr_i : '0;
        s_dat_o  = m1_cyc_i ? m1_dat_i : '0;
        m1_ack_o = s_ack_i | timeout;
        m1_dat_o = timeout ? DW'(TIMEOUT_DATA) : s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios plus random traffic vs a model.
module tb_wb_master_arbiter;

  localparam int unsigned TC = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc, stb, we;
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wdat[2];
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        m0_ack, m1_ack, err, err_clr;
  logic [31:0] m0_dat, m1_dat;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(TC)
  ) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .m0_cyc_i (cyc[0]),   .m0_stb_i (stb[0]),  .m0_we_i (we[0]),
    .m0_sel_i (sel[0]),   .m0_adr_i (adr[0]),  .m0_dat_i(wdat[0]),
    .m0_ack_o (m0_ack),   .m0_dat_o (m0_dat),
    .m1_cyc_i (cyc[1]),   .m1_stb_i (stb[1]),  .m1_we_i (we[1]),
    .m1_sel_i (sel[1]),   .m1_adr_i (adr[1]),  .m1_dat_i(wdat[1]),
    .m1_ack_o (m1_ack),   .m1_dat_o (m1_dat),
    .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),   .s_we_o  (s_we),
    .s_sel_o  (s_sel),    .s_adr_o  (s_adr),   .s_dat_o (s_wdat),
    .s_ack_i  (s_ack),    .s_dat_i  (s_rdat),
    .err_o    (err),      .err_clr_i(err_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner of the bus (-1 none), last winner, stall count, sticky error.
  int owner  = -1;
  int last   = 1;
  int stalls = 0;
  bit err_m  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Compare all outputs at the falling edge, advance the model, return just after the rise.
  task automatic step();
    bit          g, ecyc, estb, tmo;
    int          o;
    logic [31:0] edat;
    @(negedge clk);
    g    = (owner >= 0);
    o    = g ? owner : 0;
    ecyc = g && cyc[o];
    estb = ecyc && stb[o];
    tmo  = TmoEn && estb && !s_ack && (stalls == TC);
    edat = tmo ? 32'hDEAD_BEEF : s_rdat;
    check("s_cyc", s_cyc, ecyc);
    check("s_stb", s_stb, estb);
    check("s_we",  s_we,  ecyc && we[o]);
    check("s_sel", s_sel, ecyc ? sel[o]  : 4'h0);
    check("s_adr", s_adr, ecyc ? adr[o]  : 32'h0);
    check("s_dat", s_wdat, ecyc ? wdat[o] : 32'h0);
    check("m0_ack", m0_ack, g && o == 0 && (s_ack || tmo));
    check("m1_ack", m1_ack, g && o == 1 && (s_ack || tmo));
    check("m0_dat", m0_dat, (g && o == 0) ? edat : 32'h0);
    check("m1_dat", m1_dat, (g && o == 1) ? edat : 32'h0);
    check("err", err, err_m);
    if (rst) begin
      owner = -1; last = 1; stalls = 0; err_m = 1'b0;
    end else begin
      if (!g || s_ack || tmo) stalls = 0;
      else if (estb) stalls++;
      if (tmo) err_m = 1'b1;
      else if (err_clr) err_m = 1'b0;
      if (!g) begin
        if (cyc == 2'b11) owner = 1 - last;
        else if (cyc[0]) owner = 0;
        else if (cyc[1]) owner = 1;
        if (owner >= 0) last = owner;
      end else if (!cyc[o] || tmo) begin
        owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    int g;
    int seen;
    rst = 1'b1; cyc = '0; stb = '0; we = '0; err_clr = 1'b0;
    s_ack = 1'b0; s_rdat = '0;
    for (int n = 0; n < 2; n++) begin
      sel[n] = 4'hF; wdat[n] = 32'h0;
    end
    adr[0] = 32'h3000_0000; adr[1] = 32'h3000_0100;
    #1;
    do_reset();
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_err", err, 1'b0);

    // 1: m0 read, slave acks on third strobe cycle
    cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    check("t1_scyc_rise", s_cyc, 1'b1);
    step(); step();
    s_ack = 1'b1; s_rdat = 32'hCAFE_0001; #1;
    check("t1_m0_ack", m0_ack, 1'b1);
    check("t1_m0_dat", m0_dat, 32'hCAFE_0001);
    check("t1_m1_ack", m1_ack, 1'b0);
    step();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    step(); step();

    // 2: simultaneous request after reset; m0 first, one idle turnaround, then m1
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    step();
    check("t2_first_m0", s_adr, 32'h3000_0000);
    s_ack = 1'b1; step();
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    check("t2_turnaround", s_cyc, 1'b0);
    step();
    check("t2_then_m1", s_adr, 32'h3000_0100);
    cyc[0] = 1'b1; stb[0] = 1'b1;

    // 3: both request continuously; single-beat cycles must alternate
    cyc[1] = 1'b0; step(); cyc[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 4 && !s_cyc; w++) step();
      check("t3_granted", s_cyc, 1'b1);
      g = (s_adr == adr[1]) ? 1 : 0;
      check("t3_alternate", g, k % 2);
      s_ack = 1'b1; step();
      s_ack = 1'b0; cyc[g] = 1'b0; step(); cyc[g] = 1'b1;
    end
    cyc = '0; stb = '0; step(); step();

    // 4: m1 three-beat write burst holds the bus against m0
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_ack = 1'b1; #1;
      check("t4_m1_ack", m1_ack, 1'b1);
      check("t4_m0_ack", m0_ack, 1'b0);
      step();
      s_ack = 1'b0; step();
    end
    check("t4_still_m1", s_adr, 32'h3000_0100);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    step(); step();
    check("t4_m0_after", s_adr, 32'h3000_0000);
    cyc = '0; stb = '0; step(); step();

    // 5: reset in GNT1 drops the cycle, discards a late ack, then a tie goes to m0
    cyc = 2'b10; stb = 2'b10;
    step();
    check("t5_gnt1", s_adr, 32'h3000_0100);
    rst = 1'b1; step();
    rst = 1'b0; cyc = 2'b11; stb = 2'b11; s_ack = 1'b1; #1;
    check("t5_scyc_drop", s_cyc, 1'b0);
    check("t5_ack_discard", m1_ack, 1'b0);
    step();
    check("t5_tie_m0", s_adr, 32'h3000_0000);
    s_ack = 1'b0; cyc = '0; stb = '0; step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // 6: slave never acks; timeout ack with DEAD_BEEF, sticky error until cleared
    cyc[0] = 1'b1; stb[0] = 1'b1; seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      if (m0_ack) begin
        seen = i;
        check("t6_tmo_dat", m0_dat, 32'hDEAD_BEEF);
      end
      step();
    end
    check("t6_tmo_cycle", seen, 9);
    check("t6_err_set", err, 1'b1);
    check("t6_scyc_drop", s_cyc, 1'b0);
    cyc = '0; stb = '0; step(); step();
    check("t6_err_sticky", err, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t6_err_clr", err, 1'b0);
`endif

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(99) == 0);
      err_clr = ($urandom_range(15) == 0);
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(4) == 0) cyc[n] = ~cyc[n];
        stb[n]  = ($urandom_range(3) != 0);
        we[n]   = $urandom_range(1);
        sel[n]  = 4'($urandom);
        adr[n]  = $urandom;
        wdat[n] = $urandom;
      end
      s_ack  = ($urandom_range(TmoEn ? 5 : 2) == 0);
      s_rdat = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
